// File: rtl/ceas_timp_pkg.sv
// Shared types, limits and wrap-increment helpers for the clock timekeeping core.
package ceas_pkg;

  localparam int MINUTE_MAX = 59;
  localparam int ORE_MAX    = 23;
  localparam int MINUTE_W   = 6;
  localparam int ORE_W      = 5;

  typedef logic [MINUTE_W-1:0] minute_t;
  typedef logic [ORE_W-1:0]    ore_t;

  typedef enum logic [1:0] {RUN, SET_ORE, SET_MIN} state_t;

  function automatic minute_t inc_minute(input minute_t m);
    return (m == minute_t'(MINUTE_MAX)) ? '0 : m + 1'b1;
  endfunction

  function automatic ore_t inc_ore(input ore_t h);
    return (h == ore_t'(ORE_MAX)) ? '0 : h + 1'b1;
  endfunction

endpackage

// File: rtl/ceas_timp_if.sv
// Button inputs and time outputs of ceas_timp; slave = timekeeping core, master = user/display side.
interface ceas_timp_if;
  import ceas_pkg::*;

  logic    buton_setare;
  logic    buton_inc;
  minute_t minute;
  ore_t    ore;
  minute_t minute_setare;
  ore_t    ore_setare;
  logic    semnal_setare;
  logic    tick_minut;

  modport master (
    output buton_setare, buton_inc,
    input  minute, ore, minute_setare, ore_setare, semnal_setare, tick_minut
  );

  modport slave (
    input  buton_setare, buton_inc,
    output minute, ore, minute_setare, ore_setare, semnal_setare, tick_minut
  );

endinterface

// File: rtl/ceas_timp_detector_front.sv
// Registered 1-bit rising-edge detector: rise pulses one cycle after the first high sample.
module detector_front (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic rise
);

  logic prev;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      prev <= d;
      rise <= d & ~prev;
    end
  end

endmodule

// File: rtl/ceas_timp.sv
// Timekeeping core: minute prescaler, running hh:mm, and the two-button set-mode FSM.
// Optional set-mode inactivity timeout enabled by defining CEAS_TIMEOUT_EN.
module ceas_timp
  import ceas_pkg::*;
#(
  parameter int TICKS_PER_MIN  = 60_000_000,
  parameter int TIMEOUT_CYCLES = 600_000_000
) (
  input  logic        clock,
  input  logic        reset_n,
  ceas_timp_if.slave  bus
);

  localparam int PRESC_W = $clog2(TICKS_PER_MIN);

  logic [1:0] btn, btn_rise;
  logic       set_rise, inc_rise;

  // bit 1 = setare, bit 0 = inc
  assign btn = {bus.buton_setare, bus.buton_inc};
  assign set_rise = btn_rise[1];
  assign inc_rise = btn_rise[0];

  detector_front u_det [1:0] (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (btn),
    .rise    (btn_rise)
  );

  state_t              state;
  logic [PRESC_W-1:0]  presc;
  minute_t             minute_q, minute_set_q;
  ore_t                ore_q, ore_set_q;
  logic                semnal_q, tick_q;
  logic                to_hit;

`ifdef CEAS_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  logic [TO_W-1:0] to_cnt;

  // Held at zero in RUN, so entering set mode always starts from a clean count.
  always_ff @(posedge clock) begin
    if (!reset_n)
      to_cnt <= '0;
    else if (state == RUN || set_rise || inc_rise)
      to_cnt <= '0;
    else if (!to_hit)
      to_cnt <= to_cnt + 1'b1;
  end

  assign to_hit = (state != RUN) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= RUN;
      presc        <= '0;
      minute_q     <= '0;
      ore_q        <= '0;
      minute_set_q <= '0;
      ore_set_q    <= '0;
      semnal_q     <= 1'b0;
      tick_q       <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (presc == PRESC_W'(TICKS_PER_MIN - 1)) begin
        presc    <= '0;
        tick_q   <= 1'b1;
        minute_q <= inc_minute(minute_q);
        if (minute_q == minute_t'(MINUTE_MAX))
          ore_q <= inc_ore(ore_q);
      end else begin
        presc <= presc + 1'b1;
      end

      // Later assignments here override the tick update above, so a commit wins over a tick.
      case (state)
        RUN: begin
          if (set_rise) begin
            state        <= SET_ORE;
            semnal_q     <= 1'b1;
            minute_set_q <= minute_q;
            ore_set_q    <= ore_q;
          end
        end
        SET_ORE: begin
          if (set_rise)
            state <= SET_MIN;
          else if (inc_rise)
            ore_set_q <= inc_ore(ore_set_q);
          else if (to_hit) begin
            state    <= RUN;
            semnal_q <= 1'b0;
          end
        end
        SET_MIN: begin
          if (set_rise) begin
            state    <= RUN;
            semnal_q <= 1'b0;
            minute_q <= minute_set_q;
            ore_q    <= ore_set_q;
            presc    <= '0;
          end else if (inc_rise)
            minute_set_q <= inc_minute(minute_set_q);
          else if (to_hit) begin
            state    <= RUN;
            semnal_q <= 1'b0;
          end
        end
        default: begin
          state    <= RUN;
          semnal_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.minute        = minute_q;
  assign bus.ore           = ore_q;
  assign bus.minute_setare = minute_set_q;
  assign bus.ore_setare    = ore_set_q;
  assign bus.semnal_setare = semnal_q;
  assign bus.tick_minut    = tick_q;

endmodule

// File: tb/tb_ceas_timp.sv
// Directed bench for ceas_timp with TICKS_PER_MIN=4, TIMEOUT_CYCLES=20.
module tb_ceas_timp;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  ceas_timp_if bus ();

  ceas_timp #(.TICKS_PER_MIN(4), .TIMEOUT_CYCLES(20)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef enum {OP_IDLE, OP_SET, OP_INC, OP_BOTH, OP_HOLD} op_e;
  typedef struct {
    op_e op;
    int  n;
    int  e_min, e_ore, e_mset, e_oset, e_sem, e_tick;  // -1 = not checked
  } vec_t;

  vec_t tbl [24];
  int n_chk = 0;
  int n_fail = 0;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic press(input logic s, input logic i);
    bus.buton_setare = s;
    bus.buton_inc    = i;
    cyc(1);
    bus.buton_setare = 1'b0;
    bus.buton_inc    = 1'b0;
    cyc(1);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    if (exp < 0) return;
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int em, input int eo, input int ems,
                         input int eos, input int es, input int et);
    chk({tag, " minute"},        int'(bus.minute),        em);
    chk({tag, " ore"},           int'(bus.ore),           eo);
    chk({tag, " minute_setare"}, int'(bus.minute_setare), ems);
    chk({tag, " ore_setare"},    int'(bus.ore_setare),    eos);
    chk({tag, " semnal_setare"}, int'(bus.semnal_setare), es);
    chk({tag, " tick_minut"},    int'(bus.tick_minut),    et);
  endtask

  initial begin
    bus.buton_setare = 1'b0;
    bus.buton_inc    = 1'b0;

    // Edge counts in comments are posedges since reset release.
    tbl[0]  = '{OP_SET,   1, 1, 0, 1, 0, 1, 0};     // e6: enter SET_ORE, copy 00:01
    tbl[1]  = '{OP_INC,  23, 13, 0, 1, 23, 1, 1};   // e52: tick, ore_setare 23
    tbl[2]  = '{OP_SET,   1, 13, 0, 1, 23, 1, 0};   // e54: SET_MIN
    tbl[3]  = '{OP_INC,  58, -1, -1, 59, 23, 1, -1};
    tbl[4]  = '{OP_SET,   1, 59, 23, 59, 23, 0, 1}; // e172: commit on tick edge
    tbl[5]  = '{OP_IDLE,  3, 59, 23, 59, 23, 0, 0};
    tbl[6]  = '{OP_IDLE,  1, 0, 0, 59, 23, 0, 1};   // e176: 23:59 -> 00:00
    tbl[7]  = '{OP_SET,   1, 0, 0, 0, 0, 1, 0};
    tbl[8]  = '{OP_INC,  10, -1, -1, 0, 10, 1, -1};
    tbl[9]  = '{OP_SET,   1, -1, -1, 0, 10, 1, -1};
    tbl[10] = '{OP_INC,  44, -1, -1, 44, 10, 1, -1};
    tbl[11] = '{OP_SET,   1, 44, 10, 44, 10, 0, 0}; // e290: running 10:44
    tbl[12] = '{OP_SET,   1, 44, 10, 44, 10, 1, 0};
    tbl[13] = '{OP_INC,  14, -1, -1, 44, 0, 1, -1}; // hour wraps through 23
    tbl[14] = '{OP_SET,   1, -1, -1, 44, 0, 1, -1};
    tbl[15] = '{OP_INC,  16, -1, -1, 0, 0, 1, -1};  // minute wraps through 59
    tbl[16] = '{OP_SET,   1, 0, 0, 0, 0, 0, 0};     // e356: commit 00:00
    tbl[17] = '{OP_SET,   1, 0, 0, 0, 0, 1, 0};
    tbl[18] = '{OP_BOTH,  1, 1, 0, 0, 0, 1, 1};     // setare wins, inc dropped
    tbl[19] = '{OP_HOLD, 10, 3, 0, 1, 0, 1, 0};     // held inc counts once
    tbl[20] = '{OP_IDLE,  3, 4, 0, 1, 0, 1, 0};
    tbl[21] = '{OP_SET,   1, 1, 0, 1, 0, 0, 1};     // e376: commit beats tick
    tbl[22] = '{OP_IDLE,  3, 1, 0, 1, 0, 0, 0};
    tbl[23] = '{OP_IDLE,  1, 2, 0, 1, 0, 0, 1};     // next tick 4 cycles after commit

    reset_n = 1'b0;
    cyc(3);
    reset_n = 1'b1;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    cyc(3);
    chk_all("pre_tick", 0, 0, 0, 0, 0, 0);
    cyc(1);
    chk_all("first_tick", 1, 0, 0, 0, 0, 1);

    for (int i = 0; i < 24; i++) begin
      case (tbl[i].op)
        OP_IDLE: cyc(tbl[i].n);
        OP_SET:  repeat (tbl[i].n) press(1'b1, 1'b0);
        OP_INC:  repeat (tbl[i].n) press(1'b0, 1'b1);
        OP_BOTH: press(1'b1, 1'b1);
        OP_HOLD: begin
          bus.buton_inc = 1'b1;
          cyc(tbl[i].n);
          bus.buton_inc = 1'b0;
          cyc(1);
        end
        default: cyc(1);
      endcase
      chk_all($sformatf("row%0d", i), tbl[i].e_min, tbl[i].e_ore, tbl[i].e_mset,
              tbl[i].e_oset, tbl[i].e_sem, tbl[i].e_tick);
    end

    // Set-mode idle: edit minute_setare then leave the buttons alone.
    press(1'b1, 1'b0);
    chk_all("idle_enter", -1, -1, 2, 0, 1, -1);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    chk_all("idle_edit", -1, -1, 3, 0, 1, -1);
`ifdef CEAS_TIMEOUT_EN
    cyc(19);
    chk_all("timeout_pre", -1, -1, 3, 0, 1, -1);
    cyc(1);
    chk_all("timeout", 8, 0, 3, 0, 0, -1);
`else
    cyc(100);
    chk_all("no_timeout", -1, -1, 3, 0, 1, -1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
